// File: rtl/seq_div16x8.sv
// Sequential restoring divider: DVD_W-bit dividend / DVS_W-bit divisor, one quotient bit per clock.
// Uses the start/done_flag handshake and 3-bit state_out of the companion sequential multiplier.
module seq_div16x8 #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             done_flag,
  output logic             div_zero,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DONE = 3'd2,
    ERR  = 3'd3
  } state_t;

  state_t           state;
  logic [DVD_W-1:0] shift;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W:0]   p;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic             q_bit;
  logic [DVS_W:0]   p_next;
  logic [DVD_W-1:0] shift_next;
  logic             last_iter;

  // P stays below the divisor, so the trial value always fits in DVS_W+1 bits.
  always_comb begin
    trial      = {p[DVS_W-1:0], shift[DVD_W-1]};
    diff       = trial - {1'b0, dvs};
    q_bit      = (trial >= {1'b0, dvs});
    p_next     = q_bit ? diff : trial;
    shift_next = {shift[DVD_W-2:0], q_bit};
    last_iter  = (cnt == CNT_W'(DVD_W - 1));
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      shift     <= '0;
      dvs       <= '0;
      p         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            if (divisor == '0) begin
              state <= ERR;
            end else begin
              shift <= dividend;
              dvs   <= divisor;
              p     <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          shift <= shift_next;
          p     <= p_next;
          cnt   <= cnt + CNT_W'(1);
          // Results are published only when the final quotient bit lands.
          if (last_iter) begin
            quotient  <= shift_next;
            remainder <= p_next[DVS_W-1:0];
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_flag = (state == DONE);
  assign div_zero  = (state == ERR);
  assign state_out = state;

endmodule

// File: tb/tb_seq_div16x8.sv
// Directed self-checking bench for seq_div16x8: hand-computed quotients/remainders,
// latency, divide-by-zero, ignored mid-calc start, back-to-back and async reset.
module tb_seq_div16x8;

  logic        clk;
  logic        aclr_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        div_zero;
  logic [2:0]  state_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_q;
  logic [7:0]  prev_r;

  seq_div16x8 dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done_flag (done_flag),
    .div_zero  (div_zero),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues a one-cycle start at a negedge, then checks latency and the final result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] exp_q, input logic [7:0] exp_r);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_calc_state"}, state_out, 3'd1);
    check({tag, "_calc_done"}, done_flag, 1'b0);
    repeat (15) @(negedge clk);
    check({tag, "_edge15_state"}, state_out, 3'd1);
    check({tag, "_hold_q"}, quotient, prev_q);
    check({tag, "_hold_r"}, remainder, prev_r);
    @(negedge clk);
    check({tag, "_done"}, done_flag, 1'b1);
    check({tag, "_done_state"}, state_out, 3'd2);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  initial begin
    aclr_n   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    prev_q   = '0;
    prev_r   = '0;
    #12;
    check("reset_state", state_out, 3'd0);
    check("reset_q", quotient, 16'd0);
    check("reset_r", remainder, 8'd0);
    check("reset_done", done_flag, 1'b0);
    check("reset_dz", div_zero, 1'b0);
    @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk);
    check("idle_state", state_out, 3'd0);

    run_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6);

    // Divide by zero: results untouched, ERR sticks until next start.
    dividend = 16'd1234;
    divisor  = 8'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_state", state_out, 3'd3);
    check("err_dz", div_zero, 1'b1);
    check("err_done", done_flag, 1'b0);
    check("err_q", quotient, 16'd142);
    check("err_r", remainder, 8'd6);
    @(negedge clk);
    check("err_hold", state_out, 3'd3);
    run_op("d50_7", 16'd50, 8'd7, 16'd7, 8'd1);
    check("err_cleared", div_zero, 1'b0);

    run_op("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0);
    run_op("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0);
    run_op("d100_200", 16'd100, 8'd200, 16'd0, 8'd100);
    run_op("d0_5", 16'd0, 8'd5, 16'd0, 8'd0);

    // Start and operand changes during CALC must be ignored.
    dividend = 16'd30000;
    divisor  = 8'd123;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd9999;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midcalc_state", state_out, 3'd1);
    repeat (10) @(negedge clk);
    check("midcalc_edge15", state_out, 3'd1);
    @(negedge clk);
    check("midcalc_done", done_flag, 1'b1);
    check("midcalc_q", quotient, 16'd243);
    check("midcalc_r", remainder, 8'd111);

    // Start held high from DONE: back-to-back operations every 17 cycles.
    dividend = 16'd5000;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    check("b2b_a_state", state_out, 3'd1);
    check("b2b_a_done", done_flag, 1'b0);
    dividend = 16'd7770;
    divisor  = 8'd77;
    repeat (15) @(negedge clk);
    check("b2b_a_edge15", state_out, 3'd1);
    @(negedge clk);
    check("b2b_a_done2", done_flag, 1'b1);
    check("b2b_a_q", quotient, 16'd555);
    check("b2b_a_r", remainder, 8'd5);
    @(negedge clk);
    check("b2b_b_state", state_out, 3'd1);
    check("b2b_b_hold_q", quotient, 16'd555);
    repeat (15) @(negedge clk);
    check("b2b_b_edge15", state_out, 3'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_b_done", done_flag, 1'b1);
    check("b2b_b_q", quotient, 16'd100);
    check("b2b_b_r", remainder, 8'd70);
    @(negedge clk);
    check("b2b_stay_done", state_out, 3'd2);
    prev_q = 16'd100;
    prev_r = 8'd70;

    // Asynchronous reset in the middle of CALC, between clock edges.
    dividend = 16'd12345;
    divisor  = 8'd67;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_state", state_out, 3'd1);
    #1;
    aclr_n = 1'b0;
    #1;
    check("arst_state", state_out, 3'd0);
    check("arst_q", quotient, 16'd0);
    check("arst_r", remainder, 8'd0);
    check("arst_done", done_flag, 1'b0);
    check("arst_dz", div_zero, 1'b0);
    @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", state_out, 3'd0);
    prev_q = '0;
    prev_r = '0;
    run_op("d40000_200", 16'd40000, 8'd200, 16'd200, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
